line_assembler: RTL and testbench

- Sits between the UART receive path and the tokenizer.
- Collects received bytes into a fixed-length line buffer and applies backspace editing.
- On end-of-line, presents the completed line (characters plus length) with a ready flag, then holds it stable until the consumer acknowledges it.
- Produces exactly the line/length/ready interface that the tokenizer samples.

---
 rtl/line_assembler.sv | 139 +++++++++++++
 tb/tb_line_assembler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_assembler.sv
// Line assembler between the UART receiver and the tokenizer: gathers bytes into a
// fixed-length line with backspace editing and holds each completed line until it is acknowledged.
module line_assembler #(
    parameter int          LENGTH      = 16,
    parameter logic [7:0]  EOL         = 8'h0A,
    parameter logic [7:0]  CR          = 8'h0D,
    parameter logic [7:0]  BS          = 8'h08,
    parameter logic [7:0]  DEL         = 8'h7F,
    localparam int         LENGTH_BITS = $clog2(LENGTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic [7:0]             i_data,
    input  logic                   i_valid,
    output logic                   o_rx_ready,
    output logic [7:0]             o_line [LENGTH-1:0],
    output logic [LENGTH_BITS-1:0] o_len,
    output logic                   o_ready,
    input  logic                   i_ack,
    output logic                   o_overflow
);

    localparam int                   CHAR_W = 8;
    localparam logic [LENGTH_BITS-1:0] ONE  = LENGTH_BITS'(1);
    // Two slots are reserved beyond the text so EOL always fits and o_len stays below LENGTH.
    localparam logic [LENGTH_BITS-1:0] CAP  = LENGTH_BITS'(LENGTH - 2);

    typedef enum logic {
        COLLECT = 1'b0,
        READY   = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [CHAR_W-1:0]        line_q [LENGTH-1:0];
    logic [CHAR_W-1:0]        line_d [LENGTH-1:0];
    logic [LENGTH_BITS-1:0]   len_q, len_d;
    logic                     ready_q, ready_d;
    logic                     overflow_q, overflow_d;
    logic [LENGTH_BITS-1:0]   len_m1_s;

    function automatic logic is_printable(input logic [CHAR_W-1:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

    function automatic logic is_eol(input logic [CHAR_W-1:0] c);
        return (c == EOL) || (c == CR);
    endfunction

    function automatic logic is_erase(input logic [CHAR_W-1:0] c);
        return (c == BS) || (c == DEL);
    endfunction

    assign len_m1_s   = len_q - ONE;
    assign o_rx_ready = (state_q == COLLECT) && i_en && !i_rst;
    assign o_line     = line_q;
    assign o_len      = len_q;
    assign o_ready    = ready_q;
    assign o_overflow = overflow_q;

    // Next-state decode: byte editing in COLLECT, acknowledge handling in READY.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        len_d      = len_q;
        ready_d    = ready_q;
        overflow_d = 1'b0;
        if (i_en) begin
            case (state_q)
                COLLECT: begin
                    if (i_valid) begin
                        if (is_eol(i_data)) begin
                            line_d[len_q] = EOL;
                            len_d         = len_q + ONE;
                            state_d       = READY;
                            ready_d       = 1'b1;
                        end else if (is_erase(i_data)) begin
                            if (len_q != '0) begin
                                line_d[len_m1_s] = 8'h00;
                                len_d            = len_m1_s;
                            end else begin
                                len_d = len_q;
                            end
                        end else if (is_printable(i_data)) begin
                            if (len_q < CAP) begin
                                line_d[len_q] = i_data;
                                len_d         = len_q + ONE;
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end else begin
                            overflow_d = 1'b0;
                        end
                    end else begin
                        overflow_d = 1'b0;
                    end
                end
                READY: begin
                    // A byte arriving alongside the ack is dropped; the ack wins.
                    if (i_ack) begin
                        for (int i = 0; i < LENGTH; i++) begin
                            line_d[i] = 8'h00;
                        end
                        len_d   = '0;
                        ready_d = 1'b0;
                        state_d = COLLECT;
                    end else begin
                        state_d = READY;
                    end
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end else begin
            overflow_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= COLLECT;
            for (int i = 0; i < LENGTH; i++) begin
                line_q[i] <= 8'h00;
            end
            len_q      <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            len_q      <= len_d;
            ready_q    <= ready_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_line_assembler.sv
// Bench for line_assembler: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based model of the line.
module tb_line_assembler;

    localparam int LENGTH = 16;
    localparam int LB     = $clog2(LENGTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [7:0]    data;
    logic          valid;
    logic          ack;
    logic          rx_ready;
    logic [7:0]    line [LENGTH-1:0];
    logic [LB-1:0] len;
    logic          ready;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    logic [7:0] mq[$];
    bit         m_ready;
    bit         m_ovf;

    typedef struct {
        bit         en;
        bit         v;
        logic [7:0] d;
        bit         ack;
        int         len;
        bit         rdy;
        bit         ovf;
        bit         rxr;
    } vec_t;
    vec_t vt[$];

    line_assembler #(.LENGTH(LENGTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_data     (data),
        .i_valid    (valid),
        .o_rx_ready (rx_ready),
        .o_line     (line),
        .o_len      (len),
        .o_ready    (ready),
        .i_ack      (ack),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit e, input bit v, input logic [7:0] d, input bit a);
        m_ovf = 1'b0;
        if (!e) return;
        if (m_ready) begin
            if (a) begin
                mq.delete();
                m_ready = 1'b0;
            end
        end else if (v) begin
            if (d == 8'h0A || d == 8'h0D) begin
                mq.push_back(8'h0A);
                m_ready = 1'b1;
            end else if (d == 8'h08 || d == 8'h7F) begin
                if (mq.size() > 0) void'(mq.pop_back());
            end else if (d >= 8'h20 && d <= 8'h7E) begin
                if (mq.size() < LENGTH - 2) mq.push_back(d);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " len"}, int'(len), mq.size());
        check({tag, " ready"}, int'(ready), int'(m_ready));
        check({tag, " overflow"}, int'(overflow), int'(m_ovf));
        check({tag, " rx_ready"}, int'(rx_ready), int'(!m_ready && en));
        for (int i = 0; i < LENGTH; i++) begin
            check($sformatf("%s line[%0d]", tag, i), int'(line[i]),
                  (i < mq.size()) ? int'(mq[i]) : 0);
        end
    endtask

    // One clock: drive inputs, take the edge, update the model, sample 1 ns later.
    task automatic step(input bit e, input bit v, input logic [7:0] d, input bit a);
        en = e; valid = v; data = d; ack = a;
        @(posedge clk);
        model_step(e, v, d, a);
        #1;
    endtask

    function automatic void add(input bit e, input bit v, input logic [7:0] d, input bit a,
                                input int l, input bit r, input bit o, input bit x);
        vec_t t;
        t.en = e; t.v = v; t.d = d; t.ack = a; t.len = l; t.rdy = r; t.ovf = o; t.rxr = x;
        vt.push_back(t);
    endfunction

    initial begin
        int ovf_cnt;
        logic [7:0] rd;

        rst = 1'b1; en = 1'b1; valid = 1'b0; data = 8'h00; ack = 1'b0;
        #2;
        check("reset len", int'(len), 0);
        check("reset ready", int'(ready), 0);
        check("reset overflow", int'(overflow), 0);
        check("reset rx_ready", int'(rx_ready), 0);
        check("reset line[0]", int'(line[0]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rx_ready after reset", int'(rx_ready), 1);

        // "1 2 +\n", byte in READY, ack
        add(1,1,8'h31,0, 1,0,0,1); add(1,1,8'h20,0, 2,0,0,1); add(1,1,8'h32,0, 3,0,0,1);
        add(1,1,8'h20,0, 4,0,0,1); add(1,1,8'h2B,0, 5,0,0,1); add(1,1,8'h0A,0, 6,1,0,0);
        add(1,0,8'h00,0, 6,1,0,0); add(1,1,8'h5A,0, 6,1,0,0); add(1,0,8'h00,1, 0,0,0,1);
        // "AB", BS, "C", CR, then ack together with a byte
        add(1,1,8'h41,0, 1,0,0,1); add(1,1,8'h42,0, 2,0,0,1); add(1,1,8'h08,0, 1,0,0,1);
        add(1,1,8'h43,0, 2,0,0,1); add(1,1,8'h0D,0, 3,1,0,0); add(1,1,8'h41,1, 0,0,0,1);
        // erase on empty line, ignored control byte, stray ack in COLLECT
        add(1,1,8'h08,0, 0,0,0,1); add(1,1,8'h7F,0, 0,0,0,1); add(1,1,8'h01,0, 0,0,0,1);
        add(1,0,8'h00,1, 0,0,0,1);
        // enable low freezes everything, in COLLECT and in READY
        add(1,1,8'h51,0, 1,0,0,1); add(0,1,8'h52,0, 1,0,0,0); add(0,1,8'h0A,0, 1,0,0,0);
        add(0,0,8'h00,1, 1,0,0,0); add(1,1,8'h0A,0, 2,1,0,0); add(0,0,8'h00,1, 2,1,0,0);
        add(1,0,8'h00,1, 0,0,0,1);

        foreach (vt[k]) begin
            step(vt[k].en, vt[k].v, vt[k].d, vt[k].ack);
            check($sformatf("vec%0d len", k), int'(len), vt[k].len);
            check($sformatf("vec%0d ready", k), int'(ready), int'(vt[k].rdy));
            check($sformatf("vec%0d overflow", k), int'(overflow), int'(vt[k].ovf));
            check($sformatf("vec%0d rx_ready", k), int'(rx_ready), int'(vt[k].rxr));
            if (k == 5) begin
                check("line 1 2 + [4]", int'(line[4]), 8'h2B);
                check("line 1 2 + [5]", int'(line[5]), 8'h0A);
            end
            if (k == 11) check("after BS line[1]", int'(line[1]), 0);
            if (k == 13) check("ABC line[1]", int'(line[1]), 8'h43);
            check_model($sformatf("vec%0d", k));
        end

        // 16 'x' then '\n': 14 stored, two overflow cycles
        ovf_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 8'h78, 0);
            if (overflow) ovf_cnt++;
            check_model($sformatf("fill%0d", i));
        end
        step(1, 1, 8'h0A, 0);
        check("fill overflow pulses", ovf_cnt, 2);
        check("fill overflow cleared", int'(overflow), 0);
        check("fill len", int'(len), 15);
        check("fill line[14]", int'(line[14]), 8'h0A);
        check("fill line[13]", int'(line[13]), 8'h78);
        step(1, 0, 8'h00, 1);
        check_model("fill ack");

        // overflow pulse is forced low when enable drops
        for (int i = 0; i < 15; i++) step(1, 1, 8'h79, 0);
        check("ovf before disable", int'(overflow), 1);
        step(0, 1, 8'h79, 0);
        check("ovf forced low", int'(overflow), 0);
        check_model("ovf disable");
        step(1, 1, 8'h0A, 0);
        step(1, 0, 8'h00, 1);
        step(1, 1, 8'h41, 0);
        step(1, 1, 8'h0A, 0);
        check("A nl len", int'(len), 2);
        step(1, 0, 8'h00, 1);

        // async reset mid-cycle after "AB"
        step(1, 1, 8'h41, 0);
        step(1, 1, 8'h42, 0);
        valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("async rst len", int'(len), 0);
        check("async rst line[0]", int'(line[0]), 0);
        check("async rst line[1]", int'(line[1]), 0);
        check("async rst rx_ready", int'(rx_ready), 0);
        #1 rst = 1'b0;
        mq.delete(); m_ready = 1'b0; m_ovf = 1'b0;
        step(1, 1, 8'h43, 0);
        step(1, 1, 8'h0A, 0);
        check("post rst len", int'(len), 2);
        check("post rst line[0]", int'(line[0]), 8'h43);
        check_model("post rst");
        step(1, 0, 8'h00, 1);

        // randomized traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 15))
                0:       rd = 8'h0A;
                1:       rd = 8'h0D;
                2:       rd = 8'h08;
                3:       rd = 8'h7F;
                4:       rd = 8'($urandom_range(0, 31));
                5:       rd = 8'($urandom_range(128, 255));
                default: rd = 8'($urandom_range(32, 126));
            endcase
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, rd,
                 $urandom_range(0, 4) == 0);
            check_model($sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
